// File: rtl/ds_scoreboard.sv
// ds_scoreboard: register-write scoreboard and decode-stall controller for the ID stage.
// Tracks, per architectural register, how many in-flight instructions (EX/MEM/WB) still
// have to write it. Decode is held while a source is pending or while its destination
// counter is saturated.
//
// Ports:
//   clk, resetn           clock (rising edge), asynchronous active-low reset
//   ds_valid              ID holds a valid instruction
//   rs1_used/rs1_addr     first source read by the ID instruction
//   rs2_used/rs2_addr     second source read by the ID instruction
//   ds_gr_we/ds_dest      ID instruction writes ds_dest
//   issue_fire            ID->EX transfer this cycle
//   wb_we/wb_dest         write-back retires a register write this cycle
//   flush                 discard all pending writes
//   ds_stall              ID must hold (ds_ready_go = !ds_stall)
//   busy_vec              bit r set when register r has pending writes
//   inflight              total pending writes
//   sb_err                sticky overflow/underflow flag, cleared only by reset
module ds_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2,
  parameter int unsigned TOT_W = 7
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ds_valid,
  input  logic                    rs1_used,
  input  logic [$clog2(NREG)-1:0] rs1_addr,
  input  logic                    rs2_used,
  input  logic [$clog2(NREG)-1:0] rs2_addr,
  input  logic                    ds_gr_we,
  input  logic [$clog2(NREG)-1:0] ds_dest,
  input  logic                    issue_fire,
  input  logic                    wb_we,
  input  logic [$clog2(NREG)-1:0] wb_dest,
  input  logic                    flush,
  output logic                    ds_stall,
  output logic [NREG-1:0]         busy_vec,
  output logic [TOT_W-1:0]        inflight,
  output logic                    sb_err
);

  localparam int unsigned AW = $clog2(NREG);
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [TOT_W-1:0] TotMax = '1;

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [TOT_W-1:0]           inflight_q, inflight_d;
  logic                       err_q, err_d;

  logic [NREG-1:0] inc_vec, dec_vec;
  // Set only when a counter really moves, so inflight stays the sum of the counters even
  // when a per-register update saturates.
  logic            inc_eff, dec_eff;
  logic            hazard1, hazard2, full;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      inc_vec[r] = issue_fire & ds_gr_we & (ds_dest == AW'(r));
      dec_vec[r] = wb_we & (wb_dest == AW'(r));
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    err_d      = err_q;
    inc_eff    = 1'b0;
    dec_eff    = 1'b0;
    inflight_d = inflight_q;
    cnt_d[0]   = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (flush) begin
        cnt_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt_q[r] == CntMax) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
          inc_eff  = 1'b1;
        end
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt_q[r] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
          dec_eff  = 1'b1;
        end
      end
    end
    if (flush) begin
      inflight_d = '0;
    end else if (inc_eff && !dec_eff) begin
      if (inflight_q == TotMax) err_d = 1'b1;
      else                      inflight_d = inflight_q + TOT_W'(1);
    end else if (dec_eff && !inc_eff) begin
      if (inflight_q == '0) err_d = 1'b1;
      else                  inflight_d = inflight_q - TOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Stall looks only at registered counts: the regfile write lands at the edge, so a
  // source retiring this cycle releases decode next cycle.
  always_comb begin
    hazard1  = rs1_used & (rs1_addr != '0) & (cnt_q[rs1_addr] != '0);
    hazard2  = rs2_used & (rs2_addr != '0) & (cnt_q[rs2_addr] != '0);
    full     = ds_gr_we & (ds_dest != '0) & (cnt_q[ds_dest] == CntMax);
    ds_stall = ds_valid & (hazard1 | hazard2 | full);
  end

  always_comb begin
    busy_vec = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      busy_vec[r] = |cnt_q[r];
    end
  end

  assign inflight = inflight_q;
  assign sb_err   = err_q;

endmodule

// File: tb/tb_ds_scoreboard.sv
module tb_ds_scoreboard;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ds_valid, rs1_used, rs2_used, ds_gr_we, issue_fire, wb_we, flush;
  logic [4:0]  rs1_addr, rs2_addr, ds_dest, wb_dest;
  logic        ds_stall, sb_err;
  logic [31:0] busy_vec;
  logic [6:0]  inflight;

  int n_vec = 0;
  int n_err = 0;

  ds_scoreboard #(.NREG(32), .CNT_W(2), .TOT_W(7)) dut (
    .clk(clk), .resetn(resetn),
    .ds_valid(ds_valid),
    .rs1_used(rs1_used), .rs1_addr(rs1_addr),
    .rs2_used(rs2_used), .rs2_addr(rs2_addr),
    .ds_gr_we(ds_gr_we), .ds_dest(ds_dest),
    .issue_fire(issue_fire),
    .wb_we(wb_we), .wb_dest(wb_dest),
    .flush(flush),
    .ds_stall(ds_stall), .busy_vec(busy_vec), .inflight(inflight), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  // Issuing into EX while decode is told to hold is illegal input.
  always @(negedge clk) begin
    if (resetn) assert (!(issue_fire && ds_stall)) else $error("issue_fire while ds_stall");
  end

  task automatic idle();
    ds_valid = 0; rs1_used = 0; rs2_used = 0; ds_gr_we = 0; issue_fire = 0;
    wb_we = 0; flush = 0; rs1_addr = 0; rs2_addr = 0; ds_dest = 0; wb_dest = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] d);
    issue_fire = 1; ds_gr_we = 1; ds_dest = d;
    cycle();
    issue_fire = 0; ds_gr_we = 0; ds_dest = 0;
  endtask

  task automatic wb(input logic [4:0] d);
    wb_we = 1; wb_dest = d;
    cycle();
    wb_we = 0; wb_dest = 0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 0;
    #2;
    resetn = 1;
    cycle();
  endtask

  task automatic test_reset();
    resetn = 0;
    for (int i = 0; i < 6; i++) begin
      issue_fire = 1'($urandom); ds_gr_we = 1'($urandom); ds_dest = 5'($urandom);
      wb_we = 1'($urandom); wb_dest = 5'($urandom); flush = 1'($urandom);
      rs2_used = 1'($urandom); rs2_addr = 5'($urandom);
      ds_valid = 1; rs1_used = 1; rs1_addr = 5;
      cycle();
      n_vec++; if (ds_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", ds_stall); end
      n_vec++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
      n_vec++; if (inflight !== 7'd0) begin n_err++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
      n_vec++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", sb_err); end
    end
    idle();
    resetn = 1;
    cycle();
  endtask

  task automatic test_raw();
    issue(5);                                // cycle 0
    ds_valid = 1; rs1_used = 1; rs1_addr = 5; // cycle 1
    #1;
    n_vec++; if (ds_stall !== 1'b1) begin n_err++; $display("FAIL raw_stall_c1 got=%b exp=1", ds_stall); end
    n_vec++; if (busy_vec !== 32'h20) begin n_err++; $display("FAIL raw_busy_c1 got=%h exp=00000020", busy_vec); end
    n_vec++; if (inflight !== 7'd1) begin n_err++; $display("FAIL raw_inflight_c1 got=%0d exp=1", inflight); end
    cycle();                                 // cycle 2
    cycle();                                 // cycle 3
    wb_we = 1; wb_dest = 5;
    #1;
    n_vec++; if (ds_stall !== 1'b1) begin n_err++; $display("FAIL raw_no_bypass got=%b exp=1", ds_stall); end
    cycle();                                 // cycle 4
    wb_we = 0; wb_dest = 0;
    #1;
    n_vec++; if (ds_stall !== 1'b0) begin n_err++; $display("FAIL raw_release got=%b exp=0", ds_stall); end
    n_vec++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL raw_busy_c4 got=%h exp=0", busy_vec); end
    n_vec++; if (inflight !== 7'd0) begin n_err++; $display("FAIL raw_inflight_c4 got=%0d exp=0", inflight); end
    idle();
  endtask

  task automatic test_r0_unused();
    do_reset();
    issue(0);
    n_vec++; if (inflight !== 7'd0) begin n_err++; $display("FAIL r0_inflight got=%0d exp=0", inflight); end
    n_vec++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL r0_busy got=%h exp=0", busy_vec); end
    issue(7);
    issue(7);
    ds_valid = 1; rs2_used = 0; rs2_addr = 7;
    #1;
    n_vec++; if (ds_stall !== 1'b0) begin n_err++; $display("FAIL unused_rs2 got=%b exp=0", ds_stall); end
    n_vec++; if (inflight !== 7'd2) begin n_err++; $display("FAIL r7_inflight got=%0d exp=2", inflight); end
    rs2_used = 1;
    #1;
    n_vec++; if (ds_stall !== 1'b1) begin n_err++; $display("FAIL used_rs2 got=%b exp=1", ds_stall); end
    ds_valid = 0;
    #1;
    n_vec++; if (ds_stall !== 1'b0) begin n_err++; $display("FAIL no_valid got=%b exp=0", ds_stall); end
    idle();
  endtask

  task automatic test_simul_sat();
    do_reset();
    issue(9);
    issue_fire = 1; ds_gr_we = 1; ds_dest = 9; wb_we = 1; wb_dest = 9;
    cycle();
    idle();
    n_vec++; if (busy_vec !== 32'h200) begin n_err++; $display("FAIL simul_busy got=%h exp=00000200", busy_vec); end
    n_vec++; if (inflight !== 7'd1) begin n_err++; $display("FAIL simul_inflight got=%0d exp=1", inflight); end
    issue(9);
    issue(9);
    n_vec++; if (inflight !== 7'd3) begin n_err++; $display("FAIL sat_inflight got=%0d exp=3", inflight); end
    ds_valid = 1; ds_gr_we = 1; ds_dest = 9;
    #1;
    n_vec++; if (ds_stall !== 1'b1) begin n_err++; $display("FAIL full_stall got=%b exp=1", ds_stall); end
    ds_dest = 10;
    #1;
    n_vec++; if (ds_stall !== 1'b0) begin n_err++; $display("FAIL not_full got=%b exp=0", ds_stall); end
    n_vec++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL pre_ovf_err got=%b exp=0", sb_err); end
    ds_valid = 0;
    issue(9);                                // forced 4th issue
    n_vec++; if (sb_err !== 1'b1) begin n_err++; $display("FAIL ovf_err got=%b exp=1", sb_err); end
    n_vec++; if (busy_vec !== 32'h200) begin n_err++; $display("FAIL ovf_busy got=%h exp=00000200", busy_vec); end
    wb(9);
    wb(9);
    n_vec++; if (busy_vec !== 32'h200) begin n_err++; $display("FAIL ovf_cnt1 got=%h exp=00000200", busy_vec); end
    wb(9);
    n_vec++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL ovf_cnt0 got=%h exp=0", busy_vec); end
    idle();
  endtask

  task automatic test_underflow();
    do_reset();
    issue(4);
    n_vec++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL uf_pre_err got=%b exp=0", sb_err); end
    wb(12);
    n_vec++; if (sb_err !== 1'b1) begin n_err++; $display("FAIL uf_err got=%b exp=1", sb_err); end
    n_vec++; if (inflight !== 7'd1) begin n_err++; $display("FAIL uf_inflight got=%0d exp=1", inflight); end
    n_vec++; if (busy_vec !== 32'h10) begin n_err++; $display("FAIL uf_busy got=%h exp=00000010", busy_vec); end
    wb(4);
    cycle();
    cycle();
    n_vec++; if (sb_err !== 1'b1) begin n_err++; $display("FAIL uf_sticky got=%b exp=1", sb_err); end
    n_vec++; if (inflight !== 7'd0) begin n_err++; $display("FAIL uf_drain got=%0d exp=0", inflight); end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    issue(3);
    issue(3);
    issue(8);
    n_vec++; if (busy_vec !== 32'h108) begin n_err++; $display("FAIL fl_busy_pre got=%h exp=00000108", busy_vec); end
    flush = 1; ds_valid = 1; rs1_used = 1; rs1_addr = 3;
    #1;
    n_vec++; if (ds_stall !== 1'b1) begin n_err++; $display("FAIL fl_cycle_stall got=%b exp=1", ds_stall); end
    ds_valid = 0; issue_fire = 1; ds_gr_we = 1; ds_dest = 3;
    cycle();
    idle();
    ds_valid = 1; rs1_used = 1; rs1_addr = 3;
    #1;
    n_vec++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL fl_busy got=%h exp=0", busy_vec); end
    n_vec++; if (inflight !== 7'd0) begin n_err++; $display("FAIL fl_inflight got=%0d exp=0", inflight); end
    n_vec++; if (ds_stall !== 1'b0) begin n_err++; $display("FAIL fl_release got=%b exp=0", ds_stall); end
    n_vec++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL fl_err got=%b exp=0", sb_err); end
    idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    issue(8);
    wb(12);                                  // sets sb_err
    n_vec++; if (sb_err !== 1'b1) begin n_err++; $display("FAIL ar_pre_err got=%b exp=1", sb_err); end
    ds_valid = 1; rs1_used = 1; rs1_addr = 8;
    #1;
    n_vec++; if (ds_stall !== 1'b1) begin n_err++; $display("FAIL ar_pre_stall got=%b exp=1", ds_stall); end
    resetn = 0;                              // mid-cycle, away from any edge
    #1;
    n_vec++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL ar_busy got=%h exp=0", busy_vec); end
    n_vec++; if (inflight !== 7'd0) begin n_err++; $display("FAIL ar_inflight got=%0d exp=0", inflight); end
    n_vec++; if (sb_err !== 1'b0) begin n_err++; $display("FAIL ar_err got=%b exp=0", sb_err); end
    n_vec++; if (ds_stall !== 1'b0) begin n_err++; $display("FAIL ar_stall got=%b exp=0", ds_stall); end
    idle();
    resetn = 1;
    cycle();
  endtask

  initial begin
    idle();
    cycle();
    test_reset();
    test_raw();
    test_r0_unused();
    test_simul_sat();
    test_underflow();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ds_scoreboard.md
# ds_scoreboard

Register-write scoreboard and decode-stall controller for the ID stage. It tracks how many in-flight instructions (EX/MEM/WB) will still write each general register. It tells the decode stage to hold, by deasserting `ds_ready_go`, until every source register it reads has been retired through the write-back port. It sits beside `id_stage` and is fed by the ID→EX issue handshake and the WS→RF write-back bus.

## Interface
- `NREG`, 32: number of architectural registers. r0 is never tracked.
- `CNT_W`, 2: per-register pending-write counter width. Maximum count is `2**CNT_W-1` = 3.
- `TOT_W`, 7: width of the total in-flight counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ds_valid`  in  1  ID holds a valid instruction.
- `rs1_used`  in  1  ID instruction reads `rs1_addr`.
- `rs1_addr`  in  5  first source register (rj).
- `rs2_used`  in  1  ID instruction reads `rs2_addr`.
- `rs2_addr`  in  5  second source register (rk or rd).
- `ds_gr_we`  in  1  ID instruction writes `ds_dest`.
- `ds_dest`  in  5  ID destination register.
- `issue_fire`  in  1  ID→EX transfer this cycle (`ds_to_es_valid && es_allowin`).
- `wb_we`  in  1  write-back retiring a register write this cycle (`rf_we`).
- `wb_dest`  in  5  write-back destination.
- `flush`  in  1  pipeline flush; discard all pending writes.
- `ds_stall`  out  1  ID must hold. `ds_ready_go = !ds_stall`.
- `busy_vec`  out  NREG  bit r set when cnt[r] != 0.
- `inflight`  out  TOT_W  total pending writes across all registers.
- `sb_err`  out  1  sticky error flag (overflow or underflow).

## Operation
- **State.** cnt[1..NREG-1], each CNT_W bits. cnt[0] is constant 0. Also `inflight` and the sticky `sb_err`.
- **inc[r]** = `issue_fire & ds_gr_we & (ds_dest==r) & (r!=0)`.
- **dec[r]** = `wb_we & (wb_dest==r) & (r!=0)`.
- **Per-register update**, in priority order:
  - `flush` → cnt[r]=0.
  - inc & dec → unchanged.
  - inc only → +1. If cnt[r] is already at max: hold at max and set `sb_err`.
  - dec only → −1. If cnt[r]==0: hold at 0 and set `sb_err`.
- **`inflight`** changes by +inc_any − dec_any, with the same flush and saturation rules. It never wraps. Writes to r0 are ignored and do not count.
- **`ds_stall`**, combinational = `ds_valid & (hazard1 | hazard2 | full)`.
  - hazard1 = `rs1_used & rs1_addr!=0 & cnt[rs1_addr]!=0`; hazard2 is the same form for rs2.
  - full = `ds_gr_we & ds_dest!=0 & cnt[ds_dest]==max`. This is a structural hold so the counter never overflows in legal use.
  - The stall uses registered counts only. There is no same-cycle write-back bypass, because the regfile write lands at the edge. A source retiring in cycle N releases the stall in cycle N+1.
- **`flush` clears `ds_stall`** only through the counters, one cycle later. In the flush cycle `ds_stall` reflects the pre-flush counts.
- **`sb_err`** clears only on reset. It is a verification and debug aid and has no functional effect.
- **`issue_fire` while `ds_stall` is high** is illegal input. The block still applies inc as specified; the bench flags it with an assertion.

## Timing
- All state updates on the `clk` rising edge. `resetn` low asynchronously clears every cnt, `inflight` and `sb_err`.
- Reset values: `busy_vec`=0, `inflight`=0, `sb_err`=0. `ds_stall`=0, since all counts are zero.
- Latency: issue in cycle N → `busy_vec`/`inflight` updated in cycle N+1.
- Write-back in cycle N → bit cleared in cycle N+1, if the count reaches 0.
- `ds_stall` has zero latency from `ds_valid`/`rs*`/`ds_*` inputs, within the same cycle.
- If `resetn` is deasserted mid-operation, counts restart from 0; any pending writes are lost, matching the pipeline reset.

## Test plan
- **Reset.** Hold `resetn`=0 and drive random inputs with `ds_valid`=1, `rs1_used`=1, `rs1_addr`=5. Required: `ds_stall`=0, `busy_vec`=0, `inflight`=0, `sb_err`=0 throughout.
- **RAW stall and release.**
  - Cycle 0: `issue_fire`, `ds_gr_we`, `ds_dest`=5.
  - Cycle 1: ID has `rs1_addr`=5 → `ds_stall`=1, `busy_vec[5]`=1, `inflight`=1.
  - Cycle 3: `wb_we`, `wb_dest`=5. Cycle 4: `ds_stall`=0, `busy_vec`=0.
- **r0 and unused sources.**
  - Issue with `ds_dest`=0 → `inflight` stays 0.
  - `rs2_addr`=7 with `rs2_used`=0 and cnt[7]=2 → no stall.
- **Simultaneous events and saturation.**
  - Issue and write-back both to r9 with cnt[9]=1 → cnt stays 1, `busy_vec[9]`=1.
  - Three issues to r9 from 0 → `ds_stall`=1 via full when the ID instruction writes r9 again.
  - Forcing a 4th issue → cnt stays 3, `sb_err`=1.
- **Underflow.** `wb_we` with `wb_dest`=12 and cnt[12]=0 → cnt stays 0, `inflight` unchanged, `sb_err`=1 and stays high until reset.
- **Flush.**
  - With cnt[3]=2, cnt[8]=1, assert `flush` together with an issue to r3 → next cycle all counts 0, `inflight`=0, stall released.
  - Also assert `resetn` low asynchronously mid-cycle → outputs clear immediately.
